// File: rtl/branch_predictor.sv
// Branch direction predictor: static BTFN, bimodal or gshare over a table of
// 2-bit saturating counters, with a sequential table-initialisation phase and
// resolved/correct branch performance counters.
module branch_predictor #(
  parameter int unsigned BHT_ADDR_BITS = 10,
  parameter int unsigned HIST_BITS     = 8,
  parameter int unsigned MODE          = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              pd_pc,
  input  logic                     pd_isB,
  input  logic                     pd_back,
  output logic                     pd_taken,
  output logic [BHT_ADDR_BITS-1:0] pd_index,
  input  logic                     up_valid,
  input  logic [BHT_ADDR_BITS-1:0] up_index,
  input  logic                     up_taken,
  input  logic                     up_hit,
  output logic                     init_done,
  output logic [31:0]              nb_branch,
  output logic [31:0]              nb_hit
);

  localparam int unsigned ENTRIES = 1 << BHT_ADDR_BITS;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [BHT_ADDR_BITS-1:0] init_ptr;
  logic [HIST_BITS-1:0]     ghr;
  logic [1:0]               table_q [ENTRIES];
  logic [BHT_ADDR_BITS-1:0] pc_index;
  logic                     upd_en;
  logic                     unused_pc_bits;

  // PC bits outside the index window do not take part in prediction
  assign unused_pc_bits = ^{pd_pc[31:BHT_ADDR_BITS+2], pd_pc[1:0]};

  // Init/run state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_INIT;
    else         state <= state_next;
  end

  // Leave INIT once the last table entry has been written
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_ptr == '1) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Decoded state outputs
  always_comb begin
    init_done = 1'b0;
    case (state)
      ST_RUN:  init_done = 1'b1;
      default: init_done = 1'b0;
    endcase
  end

  assign upd_en = up_valid & init_done;

  // Init pointer walks the table once after every reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              init_ptr <= '0;
    else if (state == ST_INIT) init_ptr <= init_ptr + BHT_ADDR_BITS'(1);
  end

  // Global history shifts in each resolved outcome (oldest bit drops out)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     ghr <= '0;
    else if (upd_en) ghr <= HIST_BITS'({ghr, up_taken});
  end

  // Resolved and correctly-predicted branch counters, wrapping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      nb_branch <= '0;
      nb_hit    <= '0;
    end else if (upd_en) begin
      nb_branch <= nb_branch + 32'd1;
      if (up_hit) nb_hit <= nb_hit + 32'd1;
    end
  end

  // Counter table: weakly-not-taken fill during INIT, saturating training in RUN
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      table_q[init_ptr] <= 2'b01;
    end else if (upd_en) begin
      if (up_taken && (table_q[up_index] != 2'b11))
        table_q[up_index] <= table_q[up_index] + 2'd1;
      else if (!up_taken && (table_q[up_index] != 2'b00))
        table_q[up_index] <= table_q[up_index] - 2'd1;
    end
  end

  // Table index: PC word bits, hashed with history in gshare
  always_comb begin
    pc_index = pd_pc[BHT_ADDR_BITS+1:2];
    pd_index = pc_index;
    if (MODE == 2) pd_index = pc_index ^ BHT_ADDR_BITS'(ghr);
  end

  // Direction: BTFN when static or table not ready, else counter MSB (no bypass)
  always_comb begin
    pd_taken = 1'b0;
    if (pd_isB) begin
      if ((MODE == 0) || !init_done) pd_taken = pd_back;
      else                           pd_taken = table_q[pd_index][1];
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: three instances (static, bimodal, gshare) share
// one stimulus stream and are checked every cycle against a table model.
module tb_branch_predictor;

  localparam int unsigned AB = 4;
  localparam int unsigned HB = 4;
  localparam int unsigned N  = 1 << AB;

  logic              clk;
  logic              resetn;
  logic [31:0]       pd_pc;
  logic              pd_isB;
  logic              pd_back;
  logic              up_valid;
  logic [AB-1:0]     up_index;
  logic              up_taken;
  logic              up_hit;
  logic [2:0]        taken;
  logic [2:0][AB-1:0] idx;
  logic [2:0]        done;
  logic [2:0][31:0]  nbb;
  logic [2:0][31:0]  nbh;

  branch_predictor #(.BHT_ADDR_BITS(AB), .HIST_BITS(HB), .MODE(0)) u_static (
    .clk(clk), .resetn(resetn), .pd_pc(pd_pc), .pd_isB(pd_isB), .pd_back(pd_back),
    .pd_taken(taken[0]), .pd_index(idx[0]), .up_valid(up_valid), .up_index(up_index),
    .up_taken(up_taken), .up_hit(up_hit), .init_done(done[0]),
    .nb_branch(nbb[0]), .nb_hit(nbh[0]));

  branch_predictor #(.BHT_ADDR_BITS(AB), .HIST_BITS(HB), .MODE(1)) u_bimodal (
    .clk(clk), .resetn(resetn), .pd_pc(pd_pc), .pd_isB(pd_isB), .pd_back(pd_back),
    .pd_taken(taken[1]), .pd_index(idx[1]), .up_valid(up_valid), .up_index(up_index),
    .up_taken(up_taken), .up_hit(up_hit), .init_done(done[1]),
    .nb_branch(nbb[1]), .nb_hit(nbh[1]));

  branch_predictor #(.BHT_ADDR_BITS(AB), .HIST_BITS(HB), .MODE(2)) u_gshare (
    .clk(clk), .resetn(resetn), .pd_pc(pd_pc), .pd_isB(pd_isB), .pd_back(pd_back),
    .pd_taken(taken[2]), .pd_index(idx[2]), .up_valid(up_valid), .up_index(up_index),
    .up_taken(up_taken), .up_hit(up_hit), .init_done(done[2]),
    .nb_branch(nbb[2]), .nb_hit(nbh[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counter values, history, edges since reset release, perf counts
  int          m_cnt [N];
  int unsigned m_ghr;
  int          m_init;
  int unsigned m_nb;
  int unsigned m_hit;

  int n_cmp;
  int n_bad;

  // DUT outputs as sampled in the most recent step
  int s_taken [3];
  int s_idx   [3];
  int s_done  [3];
  int s_nbb   [3];
  int s_nbh   [3];

  function automatic int unsigned exp_index(int mode, logic [31:0] pc);
    int unsigned i1;
    i1 = (pc >> 2) % N;
    if (mode == 2) return (i1 ^ m_ghr) % N;
    return i1;
  endfunction

  function automatic int exp_taken(int mode, logic [31:0] pc, logic isb, logic back);
    if (!isb) return 0;
    if (mode == 0 || m_init < N) return int'(back);
    return (m_cnt[exp_index(mode, pc)] >= 2) ? 1 : 0;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 0;
    m_ghr  = 0;
    m_nb   = 0;
    m_hit  = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 1;
  endtask

  // Drive one cycle of inputs, compare all outputs mid-cycle, then advance the model
  task automatic step(input logic [31:0] pc, input logic isb, input logic back,
                      input logic uv, input int ui, input logic ut, input logic uh);
    pd_pc    = pc;
    pd_isB   = isb;
    pd_back  = back;
    up_valid = uv;
    up_index = AB'(ui);
    up_taken = ut;
    up_hit   = uh;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      s_taken[k] = int'(taken[k]);
      s_idx[k]   = int'(idx[k]);
      s_done[k]  = int'(done[k]);
      s_nbb[k]   = int'(nbb[k]);
      s_nbh[k]   = int'(nbh[k]);
      check($sformatf("pd_index[m%0d]", k), idx[k], exp_index(k, pc));
      check($sformatf("pd_taken[m%0d]", k), taken[k], exp_taken(k, pc, isb, back));
      check($sformatf("init_done[m%0d]", k), done[k], (m_init >= N) ? 1 : 0);
      check($sformatf("nb_branch[m%0d]", k), nbb[k], m_nb);
      check($sformatf("nb_hit[m%0d]", k), nbh[k], m_hit);
    end
    @(posedge clk);
    if (resetn) begin
      if (m_init < N) begin
        m_init++;
      end else if (uv) begin
        if (ut && m_cnt[ui] < 3) m_cnt[ui]++;
        if (!ut && m_cnt[ui] > 0) m_cnt[ui]--;
        m_ghr = ((m_ghr << 1) | int'(ut)) % (1 << HB);
        m_nb++;
        if (uh) m_hit++;
      end
    end
    #1;
  endtask

  task automatic rand_step();
    step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         ($urandom_range(0, 9) < 7), int'($urandom_range(0, N - 1)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic mid_reset();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("async_done[m%0d]", k), done[k], 0);
      check($sformatf("async_nbb[m%0d]", k), nbb[k], 0);
      check($sformatf("async_nbh[m%0d]", k), nbh[k], 0);
    end
    check("async_ghr_index", idx[2], exp_index(1, pd_pc));
    for (int i = 0; i < 3; i++) rand_step();
    resetn = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    resetn   = 1'b0;
    pd_pc    = '0;
    pd_isB   = 1'b0;
    pd_back  = 1'b0;
    up_valid = 1'b0;
    up_index = '0;
    up_taken = 1'b0;
    up_hit   = 1'b0;
    model_reset();

    // Held in reset: everything idle
    step(32'h0, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1);
    step(32'h0, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1);
    check("rst_done", s_done[1], 0);
    check("rst_nbb", s_nbb[2], 0);
    resetn = 1'b1;

    // Initialisation: 16 cycles of BTFN with up_valid pulses that must be ignored
    for (int i = 0; i < N; i++) begin
      step($urandom, 1'b1, 1'b1, 1'b1, i, 1'($urandom_range(0, 1)), 1'b1);
      if (i == 0 || i == N - 1) begin
        for (int k = 0; k < 3; k++) begin
          check($sformatf("init_taken[m%0d]", k), s_taken[k], 1);
          check($sformatf("init_busy[m%0d]", k), s_done[k], 0);
        end
      end
    end

    // Bimodal training at index 5 with same-cycle prediction
    step(32'h14, 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b0);
    check("run_done", s_done[1], 1);
    check("no_bypass_taken", s_taken[1], 0);
    check("btfn_fwd_taken", s_taken[0], 0);
    step(32'h14, 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b1);
    check("after_1st_taken", s_taken[1], 1);
    step(32'h14, 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b1);
    step(32'h14, 1'b1, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    check("saturated_taken", s_taken[1], 1);
    step(32'h14, 1'b1, 1'b0, 1'b1, 9, 1'b1, 1'b1);
    check("after_nt_taken", s_taken[1], 1);
    step(32'h14, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("nb_branch_5", s_nbb[1], 5);
    check("nb_hit_3", s_nbh[1], 3);

    // History T,N,T,N then gshare index for pc 0x44: 1 ^ 0xA = 0xB
    step(32'h0, 1'b0, 1'b0, 1'b1, 12, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 1'b1, 12, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b0);
    step(32'h44, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("gshare_index", s_idx[2], 11);
    check("bimodal_index", s_idx[1], 1);
    check("static_index", s_idx[0], 1);
    step(32'h14, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("not_branch_m0", s_taken[0], 0);
    check("not_branch_m1", s_taken[1], 0);

    // Randomised traffic with an asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) mid_reset();
      rand_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
